// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: function codes, flag layout and
// the default set of arithmetic function codes.
package alu_pkg;

  // Function codes {f2,f1,f0} as driven into the 8-to-1 result mux.
  localparam logic [2:0] FSEL_0 = 3'd0;
  localparam logic [2:0] FSEL_1 = 3'd1;
  localparam logic [2:0] FSEL_2 = 3'd2;
  localparam logic [2:0] FSEL_3 = 3'd3;
  localparam logic [2:0] FSEL_4 = 3'd4;
  localparam logic [2:0] FSEL_5 = 3'd5;
  localparam logic [2:0] FSEL_6 = 3'd6;
  localparam logic [2:0] FSEL_7 = 3'd7;

  // Flag vector layout {Z,N,C,V}.
  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  // Codes 0 and 1 come from the adder, so only they carry meaningful C/V.
  localparam logic [7:0] ARITH_MASK_DEFAULT = 8'b0000_0011;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO: DEPTH entries of DATA_W bits, head entry shown
// on rdData. Pushes when full and pops when empty are ignored.
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that a full FIFO and an empty FIFO have different counts.
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [OCC_W-1:0]  occupancy;
  logic              doWrite;
  logic              doRead;

  assign full    = (occupancy == OCC_FULL);
  assign empty   = (occupancy == '0);
  assign doWrite = push && !full;
  assign doRead  = pop && !empty;
  assign rdData  = mem[rdPtr];

  // Storage array: written at the write pointer on an accepted push.
  // NOTE: the data array has no reset; entries are only observable once the
  // occupancy counter says they were written, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doWrite) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (doRead) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({doWrite, doRead})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the function-select mux: tags each result
// with its function code and Z/N/C/V flags, buffers it, and hands it to the
// consumer over valid/ready. Also counts retired results and keeps a sticky
// overflow indication.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int         WIDTH      = 4,
  parameter int         DEPTH      = 2,
  parameter logic [7:0] ARITH_MASK = ARITH_MASK_DEFAULT,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fsel,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_fsel,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             sticky_v,
  input  logic             clr_sticky
);

  typedef struct packed {
    logic [2:0]       fsel;
    logic [WIDTH-1:0] result;
    flags_t           flags;
  } entry_t;

  localparam int               ENTRY_W = $bits(entry_t);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  entry_t pushEntry;
  entry_t headEntry;
  logic   fifoFull;
  logic   fifoEmpty;
  logic   doPush;
  logic   doPop;
  logic   isArith;

  // in_ready depends only on occupancy, never on out_ready, so a full buffer
  // refuses a push even in a cycle where it is also being drained.
  assign in_ready  = !fifoFull;
  assign out_valid = !fifoEmpty;
  assign doPush    = in_valid && in_ready;
  assign doPop     = out_valid && out_ready;
  assign isArith   = ARITH_MASK[in_fsel];

  // Build the entry to store: result, code and flags computed at push time.
  // NOTE: every combinational output gets a default at the top of the block
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pushEntry                = '0;
    pushEntry.fsel           = in_fsel;
    pushEntry.result         = in_result;
    pushEntry.flags[FLAG_Z]  = (in_result == '0);
    pushEntry.flags[FLAG_N]  = in_result[WIDTH-1];
    pushEntry.flags[FLAG_C]  = in_cout & isArith;
    pushEntry.flags[FLAG_V]  = in_ovf & isArith;
  end

  alu_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (doPush),
    .pop    (doPop),
    .wrData (pushEntry),
    .rdData (headEntry),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Present the head entry, or all zeros when nothing is buffered.
  always_comb begin
    out_fsel   = '0;
    out_result = '0;
    out_flags  = '0;
    if (out_valid) begin
      out_fsel   = headEntry.fsel;
      out_result = headEntry.result;
      out_flags  = headEntry.flags;
    end
  end

  // Count every retired (popped) entry, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (doPop) begin
      retire_cnt <= retire_cnt + CNT_ONE;
    end
  end

  // Remember that an overflowing result was retired; clearing wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_v <= 1'b0;
    end else if (clr_sticky) begin
      sticky_v <= 1'b0;
    end else if (doPop && headEntry.flags[FLAG_V]) begin
      sticky_v <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a table of single-result vectors with
// hand-computed flags, followed by backpressure, clear-priority, streaming,
// counter-wrap and mid-transfer reset sequences.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_fsel;
  logic [3:0] in_result;
  logic       in_cout;
  logic       in_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_fsel;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] retire_cnt;
  logic       sticky_v;
  logic       clr_sticky;

  int         nChecks = 0;
  int         nFails  = 0;
  logic [7:0] expRetire;
  logic       expSticky;

  typedef struct {
    string      name;
    logic [2:0] fsel;
    logic [3:0] result;
    logic       cout;
    logic       ovf;
    logic [3:0] expFlags;
  } vec_t;

  vec_t vecs[6];

  alu_result_stage #(
    .WIDTH      (4),
    .DEPTH      (2),
    .ARITH_MASK (8'b0000_0011),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fsel    (in_fsel),
    .in_result  (in_result),
    .in_cout    (in_cout),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fsel   (out_fsel),
    .out_result (out_result),
    .out_flags  (out_flags),
    .retire_cnt (retire_cnt),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs set afterwards apply to the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] f, input logic [3:0] r, input logic c, input logic v);
    in_valid  = 1'b1;
    in_fsel   = f;
    in_result = r;
    in_cout   = c;
    in_ovf    = v;
  endtask

  task automatic idleIn();
    in_valid  = 1'b0;
    in_fsel   = 3'bx;
    in_result = 4'bx;
    in_cout   = 1'bx;
    in_ovf    = 1'bx;
  endtask

  initial begin
    vecs[0] = '{"logic_zero",  3'b010, 4'h0, 1'b1, 1'b1, 4'b1000};
    vecs[1] = '{"add_neg_cv",  3'b000, 4'h9, 1'b1, 1'b1, 4'b0111};
    vecs[2] = '{"sub_pos_v",   3'b001, 4'h7, 1'b0, 1'b1, 4'b0001};
    vecs[3] = '{"f7_masked",   3'b111, 4'hF, 1'b1, 1'b1, 4'b0100};
    vecs[4] = '{"sub_zero_c",  3'b001, 4'h0, 1'b1, 1'b0, 4'b1010};
    vecs[5] = '{"f4_plain",    3'b100, 4'h5, 1'b0, 1'b0, 4'b0000};

    rst        = 1'b1;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    idleIn();
    expRetire  = 8'd0;
    expSticky  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Idle after reset.
    check("reset_out_valid",  {31'd0, out_valid}, 32'd0);
    check("reset_in_ready",   {31'd0, in_ready}, 32'd1);
    check("reset_retire_cnt", {24'd0, retire_cnt}, 32'd0);
    check("reset_sticky_v",   {31'd0, sticky_v}, 32'd0);
    check("reset_out_result", {28'd0, out_result}, 32'd0);
    check("reset_out_fsel",   {29'd0, out_fsel}, 32'd0);
    check("reset_out_flags",  {28'd0, out_flags}, 32'd0);

    // Table: push from empty, see it one cycle later, then pop it.
    for (int i = 0; i < 6; i++) begin
      offer(vecs[i].fsel, vecs[i].result, vecs[i].cout, vecs[i].ovf);
      step();
      idleIn();
      check({vecs[i].name, "_valid"},  {31'd0, out_valid}, 32'd1);
      check({vecs[i].name, "_fsel"},   {29'd0, out_fsel}, {29'd0, vecs[i].fsel});
      check({vecs[i].name, "_result"}, {28'd0, out_result}, {28'd0, vecs[i].result});
      check({vecs[i].name, "_flags"},  {28'd0, out_flags}, {28'd0, vecs[i].expFlags});
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      expRetire = expRetire + 8'd1;
      expSticky = expSticky | vecs[i].expFlags[0];
      check({vecs[i].name, "_empty"},  {31'd0, out_valid}, 32'd0);
      check({vecs[i].name, "_retire"}, {24'd0, retire_cnt}, {24'd0, expRetire});
      check({vecs[i].name, "_sticky"}, {31'd0, sticky_v}, {31'd0, expSticky});
    end

    // clr_sticky in the same cycle as a V=1 pop: clear wins.
    offer(3'b000, 4'h1, 1'b0, 1'b1);
    step();
    idleIn();
    check("clr_pop_flags", {28'd0, out_flags}, 32'b0001);
    out_ready  = 1'b1;
    clr_sticky = 1'b1;
    step();
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    expRetire  = expRetire + 8'd1;
    expSticky  = 1'b0;
    check("clr_priority_sticky", {31'd0, sticky_v}, 32'd0);
    check("clr_priority_retire", {24'd0, retire_cnt}, {24'd0, expRetire});

    // Backpressure: fill with 1,2 and offer 3 while full.
    offer(3'b100, 4'h1, 1'b0, 1'b0);
    step();
    check("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
    offer(3'b100, 4'h2, 1'b0, 1'b0);
    step();
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    offer(3'b100, 4'h3, 1'b0, 1'b0);
    step();
    check("bp_stall_head", {28'd0, out_result}, 32'h1);
    check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;  // pop while full with 3 still offered: 3 must be refused
    step();
    expRetire = expRetire + 8'd1;
    idleIn();
    check("bp_drain_1st", {28'd0, out_result}, 32'h2);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    expRetire = expRetire + 8'd1;
    out_ready = 1'b0;
    check("bp_3_refused", {31'd0, out_valid}, 32'd0);
    check("bp_retire", {24'd0, retire_cnt}, {24'd0, expRetire});

    // Streaming at occupancy 1: preload 0, then push i+1 while popping i.
    offer(3'b100, 4'h0, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(3'b100, 4'(i + 1), 1'b0, 1'b0);
      check($sformatf("stream_result_%0d", i), {28'd0, out_result}, i);
      check($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stream_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      step();
      expRetire = expRetire + 8'd1;
    end
    idleIn();
    check("stream_last", {28'd0, out_result}, 32'd10);
    step();
    expRetire = expRetire + 8'd1;
    out_ready = 1'b0;
    check("stream_retire", {24'd0, retire_cnt}, {24'd0, expRetire});

    // Counter wrap: stream until the count reaches 255, then one final pop.
    offer(3'b100, 4'h6, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    for (int n = 0; n < 300 && expRetire != 8'hFF; n++) begin
      step();
      expRetire = expRetire + 8'd1;
    end
    check("wrap_at_ff", {24'd0, retire_cnt}, 32'hFF);
    idleIn();
    step();
    expRetire = expRetire + 8'd1;
    out_ready = 1'b0;
    check("wrap_to_zero", {24'd0, retire_cnt}, 32'd0);
    check("wrap_empty", {31'd0, out_valid}, 32'd0);

    // Reset with two entries buffered and the consumer ready.
    offer(3'b000, 4'hA, 1'b1, 1'b1);
    step();
    offer(3'b000, 4'hB, 1'b1, 1'b1);
    step();
    idleIn();
    check("rst_pre_full", {31'd0, in_ready}, 32'd0);
    check("rst_pre_retire", {24'd0, retire_cnt}, {24'd0, expRetire});
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_retire", {24'd0, retire_cnt}, 32'd0);
    check("rst_mid_sticky", {31'd0, sticky_v}, 32'd0);
    rst = 1'b0;
    step();
    out_ready = 1'b0;
    check("rst_after_valid", {31'd0, out_valid}, 32'd0);
    check("rst_after_result", {28'd0, out_result}, 32'd0);
    check("rst_after_retire", {24'd0, retire_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
